// File: rtl/reg_mem_pkg.sv
// -----------------------------------------------------------------------------
// reg_mem_pkg
// Shared types, constants and helpers for the dual-port register memory.
//   state_t          : init-sweep FSM states
//   RDW_READ_FIRST   : same-address read-during-write returns the pre-write word
//   RDW_WRITE_FIRST  : same-address read-during-write returns the merged word
//   lane_count()     : number of write-enable lanes in a word
//   even_parity()    : even-parity bit of a (zero-padded) lane value
// -----------------------------------------------------------------------------
package reg_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended,
  // which does not change an XOR reduction.
  localparam int PARITY_MAX_W = 64;

  function automatic int lane_count(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  // Stored bit that makes the lane plus the bit XOR to zero.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] value);
    return ^value;
  endfunction

endpackage : reg_mem_pkg

// File: rtl/reg_mem_init_ctrl.sv
// -----------------------------------------------------------------------------
// reg_mem_init_ctrl
// Post-reset init sweep controller. After reset it walks every address once,
// one per cycle, requesting a write of the init value, then raises ready and
// stays there until the next reset.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset (restarts the sweep at 0)
//   init_we    : sweep write request for the current init_addr
//   init_addr  : address being cleared this cycle
//   ready      : registered; high once the sweep has covered every address
// -----------------------------------------------------------------------------
module reg_mem_init_ctrl
  import reg_mem_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_we,
  output logic [ADDR_BITS-1:0] init_addr,
  output logic                 ready
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                 ready_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= ready_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    // Registered from the next state so ready rises on the same edge that
    // enters READY.
    ready_d = (state_d == ST_READY);
  end

  assign init_addr = cnt_q;

endmodule : reg_mem_init_ctrl

// File: rtl/reg_mem_dp.sv
// -----------------------------------------------------------------------------
// reg_mem_dp
// Dual-port (1 write, 1 read) register memory with per-lane write enables,
// registered read data/valid, selectable same-address read-during-write
// behaviour and a hardware init sweep that clears every word after reset.
// Optional build macro: REG_MEM_PARITY_EN adds one even-parity bit per lane
// and the parity_err output.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   wr_en      : write request (ignored while ready = 0)
//   wr_addr    : write address
//   wr_data    : write data
//   wr_be      : per-lane write enable, bit i covers lane i
//   rd_en      : read request (ignored while ready = 0)
//   rd_addr    : read address
//   rd_data    : registered read data; holds when no read is accepted
//   rd_valid   : high the cycle after an accepted read
//   ready      : high once the init sweep is complete
//   parity_err : (REG_MEM_PARITY_EN only) read word failed parity, with rd_valid
// -----------------------------------------------------------------------------
module reg_mem_dp
  import reg_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LANE_WIDTH = 8,
  parameter int                    ADDR_BITS  = 5,
  parameter int                    RDW_MODE   = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [ADDR_BITS-1:0]                          wr_addr,
  input  logic [DATA_WIDTH-1:0]                         wr_data,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0] wr_be,
  input  logic                                          rd_en,
  input  logic [ADDR_BITS-1:0]                          rd_addr,
  output logic [DATA_WIDTH-1:0]                         rd_data,
  output logic                                          rd_valid,
  output logic                                          ready
`ifdef REG_MEM_PARITY_EN
  ,
  output logic                                          parity_err
`endif
);

  localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_BITS;

  // ---------------------------------------------------------------------------
  // Init sweep controller
  // ---------------------------------------------------------------------------
  logic                 init_we;
  logic [ADDR_BITS-1:0] init_addr;

  reg_mem_init_ctrl #(
    .ADDR_BITS (ADDR_BITS)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  // ---------------------------------------------------------------------------
  // Write path: the sweep owns the array until ready; user writes only after.
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]      lane_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_accept;

  always_comb begin
    lane_we   = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (init_we) begin
      lane_we   = '1;
      mem_waddr = init_addr;
      mem_wdata = INIT_VALUE;
    end else if (ready && wr_en) begin
      lane_we = wr_be;
    end
  end

  assign rd_accept = ready && rd_en;

  // NOTE: the array has no reset; the init sweep clears it, which keeps it
  // mappable onto plain register-file/RAM cells.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) begin
        mem_q[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. byp_lane marks lanes being written to the read address this
  // cycle; only the write-first build forwards them.
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]      byp_lane;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word;

  generate
    if (RDW_MODE == RDW_WRITE_FIRST) begin : g_write_first
      assign byp_lane = (mem_waddr == rd_addr) ? lane_we : '0;
    end else begin : g_read_first
      assign byp_lane = '0;
    end
  endgenerate

  assign old_word = mem_q[rd_addr];

  always_comb begin
    rd_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (byp_lane[i]) begin
        rd_word[i*LANE_WIDTH +: LANE_WIDTH] = mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_word;
      end
    end
  end

`ifdef REG_MEM_PARITY_EN
  // ---------------------------------------------------------------------------
  // Parity: one stored bit per lane, written under the same lane mask as the
  // data so unwritten lanes keep their existing parity.
  // ---------------------------------------------------------------------------
  logic [LANES-1:0] par_q [DEPTH];
  logic [LANES-1:0] wr_par;
  logic [LANES-1:0] rd_par;
  logic [LANES-1:0] chk_par;

  always_comb begin
    wr_par = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_par[i] = even_parity(PARITY_MAX_W'(mem_wdata[i*LANE_WIDTH +: LANE_WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) begin
        par_q[mem_waddr][i] <= wr_par[i];
      end
    end
  end

  always_comb begin
    rd_par  = par_q[rd_addr];
    chk_par = '0;
    for (int i = 0; i < LANES; i++) begin
      if (byp_lane[i]) begin
        rd_par[i] = wr_par[i];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      chk_par[i] = even_parity(PARITY_MAX_W'(rd_word[i*LANE_WIDTH +: LANE_WIDTH])) ^ rd_par[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= rd_accept && (|chk_par);
    end
  end
`endif

endmodule : reg_mem_dp

// File: tb/tb_reg_mem_dp.sv
// -----------------------------------------------------------------------------
// tb_reg_mem_dp
// Self-checking bench for reg_mem_dp. Two instances share one stimulus
// stream: dut_rf (read-first) and dut_wf (write-first). A behavioural model
// pushes expected read results into queues when a read is issued; a monitor
// on the falling edge pops and compares them when the DUTs return data.
// With REG_MEM_PARITY_EN defined, parity_err is also checked.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_mem_dp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;
  localparam logic [DW-1:0] INIT_VAL = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data_rf, rd_data_wf;
  logic          rd_valid_rf, rd_valid_wf;
  logic          ready_rf, ready_wf;
`ifdef REG_MEM_PARITY_EN
  logic          perr_rf, perr_wf;
`endif

  always #5 clk = ~clk;

  reg_mem_dp #(
    .DATA_WIDTH (DW), .LANE_WIDTH (8), .ADDR_BITS (AW),
    .RDW_MODE (0), .INIT_VALUE (INIT_VAL)
  ) dut_rf (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_be (wr_be),
    .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data_rf), .rd_valid (rd_valid_rf), .ready (ready_rf)
`ifdef REG_MEM_PARITY_EN
    , .parity_err (perr_rf)
`endif
  );

  reg_mem_dp #(
    .DATA_WIDTH (DW), .LANE_WIDTH (8), .ADDR_BITS (AW),
    .RDW_MODE (1), .INIT_VALUE (INIT_VAL)
  ) dut_wf (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_be (wr_be),
    .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data_wf), .rd_valid (rd_valid_wf), .ready (ready_wf)
`ifdef REG_MEM_PARITY_EN
    , .parity_err (perr_wf)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0]    be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [DW-1:0] model_mem [DEPTH];
  int            tb_cnt = 0;
  logic          model_ready;
  logic          exp_vld = 1'b0;
  int            corrupt_addr = -1;
  logic [DW-1:0] q_rf[$];
  logic [DW-1:0] q_wf[$];
  logic          q_perr[$];

  assign model_ready = (tb_cnt == DEPTH);

  always @(posedge clk) begin
    logic          rdy;
    logic [DW-1:0] old_w;
    rdy = (tb_cnt == DEPTH);
    if (rst) begin
      tb_cnt  = 0;
      exp_vld = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_VAL;
      q_rf.delete();
      q_wf.delete();
      q_perr.delete();
    end else begin
      exp_vld = rd_en && rdy;
      if (exp_vld) begin
        old_w = model_mem[rd_addr];
        q_rf.push_back(old_w);
        q_wf.push_back((wr_en && wr_addr == rd_addr) ? merge(old_w, wr_data, wr_be) : old_w);
        q_perr.push_back(int'(rd_addr) == corrupt_addr);
      end
      if (rdy && wr_en) model_mem[wr_addr] = merge(model_mem[wr_addr], wr_data, wr_be);
      if (tb_cnt < DEPTH) tb_cnt++;
    end
  end

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  logic [DW-1:0] last_rf = '0;
  logic [DW-1:0] last_wf = '0;

  always @(negedge clk) begin
    logic [DW-1:0] e_rf, e_wf;
    logic          e_perr;
    if (rst) begin
      last_rf = '0;
      last_wf = '0;
    end else begin
      check("ready_rf", ready_rf, model_ready);
      check("ready_wf", ready_wf, model_ready);
      check("rd_valid_rf", rd_valid_rf, exp_vld);
      check("rd_valid_wf", rd_valid_wf, exp_vld);
      if (exp_vld) begin
        if (q_rf.size() == 0 || q_wf.size() == 0 || q_perr.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e_rf   = q_rf.pop_front();
          e_wf   = q_wf.pop_front();
          e_perr = q_perr.pop_front();
          check("rd_data_rf", rd_data_rf, e_rf);
          check("rd_data_wf", rd_data_wf, e_wf);
          last_rf = e_rf;
          last_wf = e_wf;
`ifdef REG_MEM_PARITY_EN
          check("parity_err_rf", perr_rf, e_perr);
          check("parity_err_wf", perr_wf, e_perr);
`endif
        end
      end else begin
        check("rd_hold_rf", rd_data_rf, last_rf);
        check("rd_hold_wf", rd_data_wf, last_wf);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    tick();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic rd(input logic [AW-1:0] ra);
    drive(1'b0, '0, '0, 4'h0, 1'b1, ra);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] be);
    drive(1'b1, wa, wd, be, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Requests during the sweep (cycle 10) must be ignored.
    idle(10);
    drive(1'b1, 5'd3, 32'h1234_5678, 4'hF, 1'b1, 5'd3);
    idle(24);

    // Post-sweep contents, back-to-back reads.
    rd(5'd0); rd(5'd17); rd(5'd31); rd(5'd3);
    idle(2);

    // Lane write merge.
    wr(5'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(5'd5, 32'h1122_3344, 4'b0101);
    rd(5'd5);
    idle(2);

    // Read-during-write on the same address, then read back.
    wr(5'd9, 32'hAAAA_AAAA, 4'b1111);
    drive(1'b1, 5'd9, 32'h5555_5555, 4'b0011, 1'b1, 5'd9);
    rd(5'd9);
    idle(2);

    // wr_be = 0 is a no-op; independent addresses in one cycle.
    wr(5'd5, 32'hFFFF_FFFF, 4'b0000);
    drive(1'b1, 5'd12, 32'h0BAD_CAFE, 4'b1111, 1'b1, 5'd5);
    rd(5'd12);
    idle(3);

    // Random mixed traffic.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)));
    end
    idle(3);

    // Mid-sweep reset: a written word must be cleared by the restarted sweep.
    wr(5'd2, 32'hFFFF_FFFF, 4'b1111);
    rd(5'd2);
    idle(1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle(20);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    idle(10);
    drive(1'b0, '0, '0, 4'h0, 1'b1, 5'd2);
    idle(24);
    rd(5'd2);
    idle(2);

`ifdef REG_MEM_PARITY_EN
    // Flip one stored data bit of addr 7 without updating its parity.
    wr(5'd7, 32'hCAFE_F00D, 4'b1111);
    wr(5'd8, 32'h0123_4567, 4'b1111);
    idle(1);
    dut_rf.mem_q[7][0] = ~dut_rf.mem_q[7][0];
    dut_wf.mem_q[7][0] = ~dut_wf.mem_q[7][0];
    model_mem[7][0]    = ~model_mem[7][0];
    corrupt_addr       = 7;
    rd(5'd7);
    rd(5'd8);
    idle(2);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_mem_dp

// File: doc/reg_mem_dp.md
Name: reg_mem_dp

Overview:
- Parametrised successor to the team's single-port register memory.
- Provides one write port and one independent read port with per-lane write enables and a registered read valid.
- Selectable read-during-write behaviour.
- Hardware init sweep clears every location after reset.
- Sits as the general-purpose scratch/register store between datapath blocks and the bus interface.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per write-enable lane.
- ADDR_BITS, 5, address width; depth = 2**ADDR_BITS.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data (read-first), 1 = new data (write-through bypass).
- INIT_VALUE, 0, value written to every word during the init sweep (DATA_WIDTH bits).

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_BITS  write address
- wr_data  input  DATA_WIDTH  write data
- wr_be  input  DATA_WIDTH/LANE_WIDTH  per-lane write enable; bit i covers bits [i*LANE_WIDTH +: LANE_WIDTH]
- rd_en  input  1  read request
- rd_addr  input  ADDR_BITS  read address
- rd_data  output  DATA_WIDTH  registered read data
- rd_valid  output  1  high one cycle after an accepted read
- ready  output  1  high when requests are accepted (init sweep complete)

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - rd_data = 0, rd_valid = 0, ready = 0.
  - FSM enters INIT with sweep counter = 0.
  - Memory contents are not reset directly.
- FSM states: INIT, READY.
  - INIT: each cycle writes INIT_VALUE to address = counter and increments the counter.
  - After address 2**ADDR_BITS-1 is written, the next state is READY.
  - INIT therefore lasts exactly 2**ADDR_BITS cycles.
  - READY persists until rst.
- rst asserted mid-sweep restarts INIT from address 0.
- ready is a registered output: high in READY, low in INIT.
- While ready = 0, wr_en and rd_en are ignored: no memory update, rd_valid stays 0.
- Write (ready = 1, wr_en = 1):
  - At the clock edge, only lanes with wr_be[i] = 1 are updated; other lanes keep their value.
  - wr_be = 0 with wr_en = 1 is a legal no-op.
- Read (ready = 1, rd_en = 1):
  - Latency 1: rd_data = mem[rd_addr] and rd_valid = 1 on the following cycle.
  - When rd_en = 0, rd_valid returns to 0 and rd_data holds its last value (it is not zeroed).
- Read-during-write, same address, same cycle:
  - RDW_MODE = 0: rd_data returns the pre-write word.
  - RDW_MODE = 1: rd_data returns the merged word, i.e. written lanes from wr_data and unwritten lanes from the old word.
- Different addresses in the same cycle: fully independent.
- Back-to-back reads and writes are supported every cycle; there is no stall.
- Address wrap does not apply: every address is in range.

Optional Feature:
- Macro: REG_MEM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit per lane, computed on write and on the init sweep.
  - Added output parity_err (1 bit), registered alongside rd_valid; high when any lane of the read word fails parity.
  - For a partial-lane write, parity of the unwritten lanes is retained unchanged.
- When undefined:
  - No parity storage and no parity_err port.
  - Behaviour is otherwise identical.

Decomposition:
- Package reg_mem_pkg:
  - state enum (ST_INIT, ST_READY)
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1 constants
  - lane-count function (DATA_WIDTH/LANE_WIDTH)
  - even-parity function
- Sub-module reg_mem_init_ctrl:
  - holds the FSM and sweep counter
  - outputs init write enable, init address and ready
- The top-level muxes between init and user write paths and holds the array and the read register.

Test Plan:
- Reset sweep: assert rst 3 cycles, release -> ready = 0 for exactly 32 cycles then 1; reading addresses 0, 17 and 31 returns 0x00000000 with rd_valid one cycle later.
- Lane write: write 0xDEADBEEF with wr_be = 4'b1111 to addr 5, then 0x11223344 with wr_be = 4'b0101 -> read addr 5 gives 0xDE22BE44.
- RDW: with addr 9 = 0xAAAAAAAA, in one cycle write 0x55555555 (be = 4'b0011) and read addr 9 -> RDW_MODE = 0 returns 0xAAAAAAAA, RDW_MODE = 1 returns 0xAAAA5555; the next read returns 0xAAAA5555.
- Ignore during init: issue wr_en (addr 3, 0x12345678) and rd_en at cycle 10 of the sweep -> rd_valid stays 0; after ready, addr 3 reads 0x00000000.
- Mid-sweep reset: assert rst at sweep cycle 20 after writing 0xFFFFFFFF to addr 2 in the prior READY phase -> ready low for a full 32 cycles after release; addr 2 reads 0.
- Parity (REG_MEM_PARITY_EN): force one stored bit flip on addr 7 via hierarchical deposit -> the read of addr 7 gives parity_err = 1 with rd_valid = 1; a clean address gives parity_err = 0.
